// File: rtl/aq_mmu_sysmap_lookup.sv
// Sysmap region table with priority lookup and a one-deep registered response stage.
// Optional MMU_SYSMAP_LOCK_EN adds cfg_lock and per-region write-once locking.
module aq_mmu_sysmap_lookup #(
  parameter int REGION_NUM = 8,
  parameter int PA_WIDTH   = 28,
  parameter int ATTR_WIDTH = 5
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
`ifdef MMU_SYSMAP_LOCK_EN
  input  logic                  cfg_lock,
`endif
  input  logic                  cfg_wen,
  input  logic [2:0]            cfg_idx,
  input  logic [PA_WIDTH-1:0]   cfg_upaddr,
  input  logic [ATTR_WIDTH-1:0] cfg_attr,
  input  logic                  req_vld,
  input  logic [PA_WIDTH-1:0]   req_pa,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic                  rsp_hit,
  output logic [2:0]            rsp_idx,
  output logic [ATTR_WIDTH-1:0] rsp_attr
);

  // Miss / reset attribute: strong-order, everything else clear.
  localparam logic [ATTR_WIDTH-1:0] ATTR_MISS = {1'b1, {(ATTR_WIDTH-1){1'b0}}};

  logic [PA_WIDTH-1:0]   upaddr_q [REGION_NUM];
  logic [ATTR_WIDTH-1:0] attr_q   [REGION_NUM];
  logic [REGION_NUM-1:0] wr_en;
  logic [REGION_NUM-1:0] hit_vec;

  logic                  lk_hit_p0;
  logic [2:0]            lk_idx_p0;
  logic [ATTR_WIDTH-1:0] lk_attr_p0;
  logic                  accept_p0;

  logic                  vld_p1;
  logic                  hit_p1;
  logic [2:0]            idx_p1;
  logic [ATTR_WIDTH-1:0] attr_p1;

`ifdef MMU_SYSMAP_LOCK_EN
  logic [REGION_NUM-1:0] lock_q;
`endif

  // Indices at or above REGION_NUM match no region, so such writes vanish.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < REGION_NUM; i++) begin
`ifdef MMU_SYSMAP_LOCK_EN
      wr_en[i] = cfg_wen && (cfg_idx == 3'(i)) && !lock_q[i];
`else
      wr_en[i] = cfg_wen && (cfg_idx == 3'(i));
`endif
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        upaddr_q[i] <= (i == REGION_NUM - 1) ? {PA_WIDTH{1'b1}} : {PA_WIDTH{1'b0}};
        attr_q[i]   <= ATTR_MISS;
      end
    end else begin
      for (int i = 0; i < REGION_NUM; i++) begin
        if (wr_en[i]) begin
          upaddr_q[i] <= cfg_upaddr;
          attr_q[i]   <= cfg_attr;
        end
      end
    end
  end

`ifdef MMU_SYSMAP_LOCK_EN
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      lock_q <= '0;
    end else begin
      for (int i = 0; i < REGION_NUM; i++) begin
        if (wr_en[i] && cfg_lock) lock_q[i] <= 1'b1;
      end
    end
  end
`endif

  // Stage p0: per-region bounds compare; bottom of region i is the top of region i-1.
  for (genvar g = 0; g < REGION_NUM; g++) begin : g_cmp
    if (g == 0) begin : g_first
      assign hit_vec[g] = req_pa < upaddr_q[g];
    end else begin : g_rest
      assign hit_vec[g] = (req_pa >= upaddr_q[g-1]) && (req_pa < upaddr_q[g]);
    end
  end

  // Walk high to low so the lowest hitting index is the one that sticks.
  always_comb begin
    lk_hit_p0  = 1'b0;
    lk_idx_p0  = 3'd0;
    lk_attr_p0 = ATTR_MISS;
    for (int i = REGION_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        lk_hit_p0  = 1'b1;
        lk_idx_p0  = 3'(i);
        lk_attr_p0 = attr_q[i];
      end
    end
  end

  assign req_rdy   = !vld_p1 || rsp_rdy;
  assign accept_p0 = req_vld && req_rdy;

  // Stage p1: response registers; data loads only on accept so a stalled response holds.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_p1  <= 1'b0;
      hit_p1  <= 1'b0;
      idx_p1  <= 3'd0;
      attr_p1 <= ATTR_MISS;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      hit_p1  <= lk_hit_p0;
      idx_p1  <= lk_idx_p0;
      attr_p1 <= lk_attr_p0;
    end else if (rsp_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

  assign rsp_vld  = vld_p1;
  assign rsp_hit  = hit_p1;
  assign rsp_idx  = idx_p1;
  assign rsp_attr = attr_p1;

endmodule

// File: tb/tb_aq_mmu_sysmap_lookup.sv
// Directed bench for aq_mmu_sysmap_lookup; responses compared as {vld,hit,idx[2:0],attr[4:0]}.
module tb_aq_mmu_sysmap_lookup;

  logic        forever_cpuclk;
  logic        cpurst_b;
`ifdef MMU_SYSMAP_LOCK_EN
  logic        cfg_lock;
`endif
  logic        cfg_wen;
  logic [2:0]  cfg_idx;
  logic [27:0] cfg_upaddr;
  logic [4:0]  cfg_attr;
  logic        req_vld;
  logic [27:0] req_pa;
  logic        req_rdy;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic        rsp_hit;
  logic [2:0]  rsp_idx;
  logic [4:0]  rsp_attr;

  int n_vec;
  int n_err;

  aq_mmu_sysmap_lookup dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
`ifdef MMU_SYSMAP_LOCK_EN
    .cfg_lock       (cfg_lock),
`endif
    .cfg_wen        (cfg_wen),
    .cfg_idx        (cfg_idx),
    .cfg_upaddr     (cfg_upaddr),
    .cfg_attr       (cfg_attr),
    .req_vld        (req_vld),
    .req_pa         (req_pa),
    .req_rdy        (req_rdy),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_hit        (rsp_hit),
    .rsp_idx        (rsp_idx),
    .rsp_attr       (rsp_attr)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  function automatic logic [9:0] rsp_word();
    return {rsp_vld, rsp_hit, rsp_idx, rsp_attr};
  endfunction

  task automatic do_write(input logic [2:0] idx, input logic [27:0] up,
                          input logic [4:0] attr, input logic lock);
    @(negedge forever_cpuclk);
    cfg_wen = 1'b1; cfg_idx = idx; cfg_upaddr = up; cfg_attr = attr;
`ifdef MMU_SYSMAP_LOCK_EN
    cfg_lock = lock;
`else
    if (lock) $display("note: lock request ignored in this build");
`endif
    @(posedge forever_cpuclk); #1;
    cfg_wen = 1'b0;
`ifdef MMU_SYSMAP_LOCK_EN
    cfg_lock = 1'b0;
`endif
  endtask

  // One accepted request with rsp_rdy=1; returns the response word one edge later.
  task automatic do_lookup(input logic [27:0] pa, output logic [9:0] obs);
    @(negedge forever_cpuclk);
    rsp_rdy = 1'b1; req_vld = 1'b1; req_pa = pa;
    @(posedge forever_cpuclk); #1;
    req_vld = 1'b0;
    obs = rsp_word();
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    cpurst_b = 1'b0;
    #12;
    n_vec++;
    if (rsp_word() !== {1'b0, 1'b0, 3'd0, 5'b10000} || req_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: rsp=%h rdy=%b, want rsp=%h rdy=1", rsp_word(), req_rdy, {1'b0, 1'b0, 3'd0, 5'b10000});
    end
    @(negedge forever_cpuclk); cpurst_b = 1'b1;
    do_lookup(28'h0000123, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd7, 5'b10000}) begin
      n_err++; $display("FAIL reset_lookup: got %h want %h", obs, {1'b1, 1'b1, 3'd7, 5'b10000});
    end
  endtask

  task automatic test_region0();
    logic [9:0] obs;
    do_write(3'd0, 28'h0080000, 5'b01110, 1'b0);
    do_lookup(28'h007FFFF, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd0, 5'b01110}) begin
      n_err++; $display("FAIL region0_below: got %h want %h", obs, {1'b1, 1'b1, 3'd0, 5'b01110});
    end
    do_lookup(28'h0080000, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd7, 5'b10000}) begin
      n_err++; $display("FAIL region0_edge: got %h want %h", obs, {1'b1, 1'b1, 3'd7, 5'b10000});
    end
  endtask

  task automatic test_nonmono();
    logic [9:0] obs;
    do_write(3'd0, 28'h0000100, 5'b01110, 1'b0);
    do_write(3'd1, 28'h0000080, 5'b00011, 1'b0);
    do_lookup(28'h0000090, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd0, 5'b01110}) begin
      n_err++; $display("FAIL nonmono_low_wins: got %h want %h", obs, {1'b1, 1'b1, 3'd0, 5'b01110});
    end
    do_write(3'd7, 28'h0000050, 5'b10101, 1'b0);
    do_lookup(28'h0000200, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b0, 3'd0, 5'b10000}) begin
      n_err++; $display("FAIL nonmono_miss: got %h want %h", obs, {1'b1, 1'b0, 3'd0, 5'b10000});
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] pas [4];
    logic [9:0]  exp [4];
    // Region2 spans [0x080,0x300) since its bottom is upaddr1.
    do_write(3'd2, 28'h0000300, 5'b00101, 1'b0);
    pas[0] = 28'h010; exp[0] = {1'b1, 1'b1, 3'd0, 5'b01110};
    pas[1] = 28'h200; exp[1] = {1'b1, 1'b1, 3'd2, 5'b00101};
    pas[2] = 28'h300; exp[2] = {1'b1, 1'b0, 3'd0, 5'b10000};
    pas[3] = 28'h2FF; exp[3] = {1'b1, 1'b1, 3'd2, 5'b00101};
    @(negedge forever_cpuclk);
    rsp_rdy = 1'b1; req_vld = 1'b1; req_pa = pas[0];
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (req_rdy !== 1'b1) begin
        n_err++; $display("FAIL b2b_rdy[%0d]: got %b want 1", k, req_rdy);
      end
      @(posedge forever_cpuclk); #1;
      n_vec++;
      if (rsp_word() !== exp[k]) begin
        n_err++; $display("FAIL b2b_rsp[%0d]: got %h want %h", k, rsp_word(), exp[k]);
      end
      if (k < 3) req_pa = pas[k+1];
      else req_vld = 1'b0;
    end
    @(posedge forever_cpuclk); #1;
    n_vec++;
    if (rsp_vld !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: rsp_vld=%b want 0", rsp_vld);
    end
  endtask

  task automatic test_stall();
    logic [9:0] obs;
    @(negedge forever_cpuclk);
    rsp_rdy = 1'b0; req_vld = 1'b1; req_pa = 28'h200;
    @(posedge forever_cpuclk); #1;
    req_pa = 28'h010;
    cfg_wen = 1'b1; cfg_idx = 3'd2; cfg_upaddr = 28'h0000300; cfg_attr = 5'b11000;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (rsp_word() !== {1'b1, 1'b1, 3'd2, 5'b00101} || req_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: rsp=%h rdy=%b want rsp=%h rdy=0", k, rsp_word(), req_rdy, {1'b1, 1'b1, 3'd2, 5'b00101});
      end
      @(posedge forever_cpuclk); #1;
      cfg_wen = 1'b0;
    end
    // Consume and accept on the same edge: valid stays up with the new data.
    rsp_rdy = 1'b1;
    @(posedge forever_cpuclk); #1;
    req_vld = 1'b0;
    n_vec++;
    if (rsp_word() !== {1'b1, 1'b1, 3'd0, 5'b01110}) begin
      n_err++; $display("FAIL stall_swap: got %h want %h", rsp_word(), {1'b1, 1'b1, 3'd0, 5'b01110});
    end
    do_lookup(28'h200, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd2, 5'b11000}) begin
      n_err++; $display("FAIL stall_write_applied: got %h want %h", obs, {1'b1, 1'b1, 3'd2, 5'b11000});
    end
  endtask

  task automatic test_same_cycle_cfg();
    logic [9:0] obs;
    @(negedge forever_cpuclk);
    rsp_rdy = 1'b1; req_vld = 1'b1; req_pa = 28'h010;
    cfg_wen = 1'b1; cfg_idx = 3'd0; cfg_upaddr = 28'h0000100; cfg_attr = 5'b00000;
    @(posedge forever_cpuclk); #1;
    req_vld = 1'b0; cfg_wen = 1'b0;
    n_vec++;
    if (rsp_word() !== {1'b1, 1'b1, 3'd0, 5'b01110}) begin
      n_err++; $display("FAIL samecyc_old: got %h want %h", rsp_word(), {1'b1, 1'b1, 3'd0, 5'b01110});
    end
    do_lookup(28'h010, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd0, 5'b00000}) begin
      n_err++; $display("FAIL samecyc_new: got %h want %h", obs, {1'b1, 1'b1, 3'd0, 5'b00000});
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    @(negedge forever_cpuclk);
    rsp_rdy = 1'b0; req_vld = 1'b1; req_pa = 28'h200;
    @(posedge forever_cpuclk); #1;
    req_vld = 1'b0;
    n_vec++;
    if (rsp_vld !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre: rsp_vld=%b want 1", rsp_vld);
    end
    #2 cpurst_b = 1'b0;
    #1;
    n_vec++;
    if (rsp_word() !== {1'b0, 1'b0, 3'd0, 5'b10000}) begin
      n_err++; $display("FAIL midrst_drop: got %h want %h", rsp_word(), {1'b0, 1'b0, 3'd0, 5'b10000});
    end
    @(negedge forever_cpuclk); cpurst_b = 1'b1;
    do_lookup(28'h200, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd7, 5'b10000}) begin
      n_err++; $display("FAIL midrst_table_a: got %h want %h", obs, {1'b1, 1'b1, 3'd7, 5'b10000});
    end
    do_lookup(28'h010, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd7, 5'b10000}) begin
      n_err++; $display("FAIL midrst_table_b: got %h want %h", obs, {1'b1, 1'b1, 3'd7, 5'b10000});
    end
  endtask

`ifdef MMU_SYSMAP_LOCK_EN
  task automatic test_lock();
    logic [9:0] obs;
    do_write(3'd2, 28'h0000300, 5'b00001, 1'b1);
    do_write(3'd2, 28'h0000400, 5'b11111, 1'b0);
    do_lookup(28'h200, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd2, 5'b00001}) begin
      n_err++; $display("FAIL lock_attr: got %h want %h", obs, {1'b1, 1'b1, 3'd2, 5'b00001});
    end
    do_lookup(28'h350, obs);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 3'd7, 5'b10000}) begin
      n_err++; $display("FAIL lock_upaddr: got %h want %h", obs, {1'b1, 1'b1, 3'd7, 5'b10000});
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0;
    cpurst_b = 1'b0;
`ifdef MMU_SYSMAP_LOCK_EN
    cfg_lock = 1'b0;
`endif
    cfg_wen = 1'b0; cfg_idx = 3'd0; cfg_upaddr = '0; cfg_attr = '0;
    req_vld = 1'b0; req_pa = '0; rsp_rdy = 1'b1;
    test_reset();
    test_region0();
    test_nonmono();
    test_back_to_back();
    test_stall();
    test_same_cycle_cfg();
    test_reset_mid();
`ifdef MMU_SYSMAP_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
